// File: rtl/traffic_conflict_monitor.sv
// rtl/traffic_conflict_monitor.sv - lamp-bus safety monitor with fault latch and flashing-red override
module traffic_conflict_monitor #(
    parameter int                           N_HEADS    = 6,
    parameter int                           FILTER     = 4,
    parameter int                           MIN_AMBER  = 8,
    parameter int                           FLASH_HALF = 16,
    parameter logic [N_HEADS*N_HEADS-1:0]   CONFLICT   = '0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [N_HEADS-1:0] lamp_r,
    input  logic [N_HEADS-1:0] lamp_a,
    input  logic [N_HEADS-1:0] lamp_g,
    input  logic               clear_fault,
    output logic               armed,
    output logic               fault,
    output logic [2:0]         fault_code,
    output logic [2:0]         fault_head,
    output logic               force_flash,
    output logic               flash_red
);
    typedef enum logic [2:0] {ASP_DARK, ASP_R, ASP_RA, ASP_G, ASP_A, ASP_BAD} aspect_t;
    typedef enum logic [1:0] {ST_UNARMED, ST_ARMED, ST_FAULT} state_t;

    localparam int CW = $clog2(FILTER + 1);
    localparam int FW = $clog2(FLASH_HALF + 1);

    function automatic aspect_t decode(input logic r, input logic a, input logic g);
        case ({r, a, g})
            3'b100:  return ASP_R;
            3'b110:  return ASP_RA;
            3'b001:  return ASP_G;
            3'b010:  return ASP_A;
            3'b000:  return ASP_DARK;
            default: return ASP_BAD;
        endcase
    endfunction

    function automatic logic legal(input aspect_t from, input aspect_t to);
        return (from == to) ||
               (from == ASP_R  && to == ASP_RA) ||
               (from == ASP_RA && to == ASP_G)  ||
               (from == ASP_G  && to == ASP_A)  ||
               (from == ASP_A  && to == ASP_R);
    endfunction

    function automatic logic [2:0] lowest(input logic [N_HEADS-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = N_HEADS - 1; k >= 0; k--) begin
            if (v[k]) idx = 3'(k);
        end
        return idx;
    endfunction

    aspect_t       raw     [N_HEADS];
    aspect_t       cand    [N_HEADS];
    aspect_t       acc     [N_HEADS];
    aspect_t       hist    [N_HEADS];
    logic [CW-1:0] cnt     [N_HEADS];
    logic [CW-1:0] cnt_nx  [N_HEADS];
    logic [15:0]   amber_t [N_HEADS];

    state_t state, state_nx;
    logic [FW-1:0] flash_cnt;

    logic [N_HEADS-1:0] is_bad, is_dark, is_seq, is_short, is_go, is_conf;
    logic               det, all_valid, all_red;
    logic [2:0]         det_code, det_head;

    always_comb begin
        for (int k = 0; k < N_HEADS; k++) begin
            raw[k] = decode(lamp_r[k], lamp_a[k], lamp_g[k]);
            if (raw[k] != cand[k])
                cnt_nx[k] = CW'(1);
            else if (cnt[k] == CW'(FILTER))
                cnt_nx[k] = cnt[k];
            else
                cnt_nx[k] = cnt[k] + 1'b1;
        end
    end

    // Accepted aspect is taken on the edge where the run of identical raw samples reaches FILTER.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < N_HEADS; k++) begin
                cand[k]    <= ASP_DARK;
                cnt[k]     <= '0;
                acc[k]     <= ASP_DARK;
                hist[k]    <= ASP_DARK;
                amber_t[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_HEADS; k++) begin
                cand[k] <= raw[k];
                cnt[k]  <= cnt_nx[k];
                if (cnt_nx[k] == CW'(FILTER)) acc[k] <= raw[k];
                hist[k] <= acc[k];
                if (acc[k] != ASP_A)
                    amber_t[k] <= '0;
                else if (amber_t[k] != 16'hFFFF)
                    amber_t[k] <= amber_t[k] + 16'd1;
            end
        end
    end

    always_comb begin
        all_valid = 1'b1;
        all_red   = 1'b1;
        for (int k = 0; k < N_HEADS; k++) begin
            is_bad[k]   = (acc[k] == ASP_BAD);
            is_dark[k]  = (acc[k] == ASP_DARK);
            is_seq[k]   = !legal(hist[k], acc[k]);
            is_short[k] = (hist[k] == ASP_A) && (acc[k] == ASP_R) && (amber_t[k] < 16'(MIN_AMBER));
            is_go[k]    = (acc[k] == ASP_G) || (acc[k] == ASP_A);
            if (is_bad[k] || is_dark[k]) all_valid = 1'b0;
            if (acc[k] != ASP_R) all_red = 1'b0;
        end
        for (int i = 0; i < N_HEADS; i++) begin
            is_conf[i] = 1'b0;
            for (int j = 0; j < N_HEADS; j++) begin
                if (j > i && CONFLICT[i*N_HEADS+j] && is_go[i] && is_go[j]) is_conf[i] = 1'b1;
            end
        end
    end

    always_comb begin
        det      = 1'b1;
        det_code = 3'd0;
        det_head = 3'd0;
        if (|is_conf) begin
            det_code = 3'd3; det_head = lowest(is_conf);
        end else if (|is_bad) begin
            det_code = 3'd1; det_head = lowest(is_bad);
        end else if (|is_seq) begin
            det_code = 3'd2; det_head = lowest(is_seq);
        end else if (|is_short) begin
            det_code = 3'd4; det_head = lowest(is_short);
        end else if (|is_dark) begin
            det_code = 3'd5; det_head = lowest(is_dark);
        end else begin
            det = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_UNARMED;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_UNARMED: if (all_valid)             state_nx = ST_ARMED;
            ST_ARMED:   if (det)                   state_nx = ST_FAULT;
            ST_FAULT:   if (clear_fault && all_red) state_nx = ST_UNARMED;
            default:                               state_nx = ST_UNARMED;
        endcase
    end

    // Fault record and flash phase restart together on fault entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fault_code <= '0;
            fault_head <= '0;
            flash_cnt  <= '0;
            flash_red  <= 1'b0;
        end else if (state == ST_ARMED && det) begin
            fault_code <= det_code;
            fault_head <= det_head;
            flash_cnt  <= '0;
            flash_red  <= 1'b1;
        end else if (state_nx == ST_FAULT) begin
            if (flash_cnt == FW'(FLASH_HALF - 1)) begin
                flash_cnt <= '0;
                flash_red <= ~flash_red;
            end else begin
                flash_cnt <= flash_cnt + 1'b1;
            end
        end else begin
            fault_code <= '0;
            fault_head <= '0;
            flash_cnt  <= '0;
            flash_red  <= 1'b0;
        end
    end

    assign armed       = (state == ST_ARMED);
    assign fault       = (state == ST_FAULT);
    assign force_flash = fault;
endmodule
